// File: rtl/philo_pkg.sv
// Shared types and helpers for the dining-philosophers ring.
package philo_pkg;

  typedef enum logic [1:0] {
    THINKING = 2'd0,
    READING  = 2'd1,
    EATING   = 2'd2,
    HUNGRY   = 2'd3
  } state_t;

  // Ring index of the cell 'offset' positions away from cell i.
  function automatic int nb_idx(input int i, input int offset, input int n);
    return (i + offset + n) % n;
  endfunction

endpackage

// File: rtl/philo_cell.sv
// One philosopher: state register, saturating hunger counter and urgency decode.
module philo_cell
  import philo_pkg::*;
#(
  parameter bit INIT_READ = 1'b0,
  parameter int CNT_W     = 4,
  parameter int URGENT_TH = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       coin,
  input  logic [1:0] l_state,
  input  logic [1:0] r_state,
  input  logic       l_urg,
  input  logic       r_urg,
  output logic [1:0] state,
  output logic       urg,
  output logic       eat_entry
);

  localparam logic [CNT_W-1:0] TH = CNT_W'(URGENT_TH);

  state_t           st_p0, st_nxt, l_st, r_st;
  logic [CNT_W-1:0] hc_p0, hc_nxt;
  logic             l_block, r_block;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign l_st  = state_t'(l_state);
  assign r_st  = state_t'(r_state);
  assign state = st_p0;
  assign urg   = (st_p0 == HUNGRY) && (hc_p0 >= TH);

  // An urgent cell overtakes a non-urgent hungry right neighbour; otherwise the right one wins.
  assign r_block = (r_st == HUNGRY) && !(urg && !r_urg);
  assign l_block = (l_st == HUNGRY) && l_urg && !urg;

  always_comb begin
    st_nxt = st_p0;
    case (st_p0)
      READING:  if (l_st == THINKING) st_nxt = THINKING;
      THINKING: begin
        if (r_st == READING) st_nxt = READING;
        else                 st_nxt = coin ? THINKING : HUNGRY;
      end
      EATING:   if (coin) st_nxt = THINKING;
      HUNGRY: begin
        if ((l_st != EATING) && (r_st != EATING) && !r_block && !l_block)
          st_nxt = EATING;
      end
      default: st_nxt = st_p0;
    endcase
  end

  assign hc_nxt    = ((st_p0 == HUNGRY) && (st_nxt == HUNGRY)) ? sat_inc(hc_p0) : '0;
  assign eat_entry = (st_p0 == HUNGRY) && (st_nxt == EATING);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st_p0 <= INIT_READ ? READING : THINKING;
      hc_p0 <= '0;
    end else begin
      st_p0 <= st_nxt;
      hc_p0 <= hc_nxt;
    end
  end

endmodule

// File: rtl/philo_ring.sv
// Ring of N philosopher cells with a sticky adjacent-eating checker and a meal counter.
module philo_ring
  import philo_pkg::*;
#(
  parameter int N           = 8,
  parameter int INIT_READER = 0,
  parameter int CNT_W       = 4,
  parameter int URGENT_TH   = 8,
  parameter int MEAL_W      = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [N-1:0]      coin,
  output logic [2*N-1:0]    state_o,
  output logic [N-1:0]      urgent_o,
  output logic              excl_err_o,
  output logic [MEAL_W-1:0] meals_o
);

  logic [N-1:0] eat_entry;
  logic [N-1:0] eating;
  logic [N-1:0] eating_r;
  logic         excl_any;

  function automatic logic [MEAL_W-1:0] count_ones(input logic [N-1:0] v);
    logic [MEAL_W-1:0] c;
    c = '0;
    for (int k = 0; k < N; k++) c = c + MEAL_W'(v[k]);
    return c;
  endfunction

  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_cell
      localparam int L = nb_idx(i, 1, N);
      localparam int R = nb_idx(i, -1, N);

      philo_cell #(
        .INIT_READ (i == INIT_READER),
        .CNT_W     (CNT_W),
        .URGENT_TH (URGENT_TH)
      ) u_cell (
        .clock     (clock),
        .reset_n   (reset_n),
        .coin      (coin[i]),
        .l_state   (state_o[2*L +: 2]),
        .r_state   (state_o[2*R +: 2]),
        .l_urg     (urgent_o[L]),
        .r_urg     (urgent_o[R]),
        .state     (state_o[2*i +: 2]),
        .urg       (urgent_o[i]),
        .eat_entry (eat_entry[i])
      );

      assign eating[i] = (state_o[2*i +: 2] == EATING);
    end
  endgenerate

  // eating_r[i] is the right neighbour (i-1) of cell i.
  assign eating_r = {eating[N-2:0], eating[N-1]};
  assign excl_any = |(eating & eating_r);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      excl_err_o <= 1'b0;
      meals_o    <= '0;
    end else begin
      excl_err_o <= excl_err_o | excl_any;
      meals_o    <= meals_o + count_ones(eat_entry);
    end
  end

endmodule

// File: tb/tb_philo_ring.sv
// Bench for philo_ring: two ring configurations checked every cycle against a rule-level model.
module tb_philo_ring;

  localparam int T = 0, RD = 1, E = 2, H = 3;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [7:0]  coin0 = '1;
  logic [4:0]  coin1 = '1;
  logic [15:0] st0;
  logic [7:0]  ur0;
  logic        ex0;
  logic [3:0]  me0;
  logic [9:0]  st1;
  logic [4:0]  ur1;
  logic        ex1;
  logic [15:0] me1;

  int total = 0;
  int bad   = 0;

  // Model state: index 0 = dut0, index 1 = dut1.
  int nn[2], ir[2], cw[2], ut[2], mw[2];
  int m_st[2][8];
  int m_hc[2][8];
  int m_meals[2];
  bit m_ex[2];

  philo_ring #(.N(8), .INIT_READER(0), .CNT_W(3), .URGENT_TH(3), .MEAL_W(4)) dut0 (
    .clock(clock), .reset_n(reset_n), .coin(coin0),
    .state_o(st0), .urgent_o(ur0), .excl_err_o(ex0), .meals_o(me0)
  );

  philo_ring #(.N(5), .INIT_READER(3), .CNT_W(3), .URGENT_TH(7), .MEAL_W(16)) dut1 (
    .clock(clock), .reset_n(reset_n), .coin(coin1),
    .state_o(st1), .urgent_o(ur1), .excl_err_o(ex1), .meals_o(me1)
  );

  always #5 clock = ~clock;

  task automatic model_reset(input int d);
    for (int i = 0; i < 8; i++) begin
      m_st[d][i] = (i == ir[d]) ? RD : T;
      m_hc[d][i] = 0;
    end
    m_meals[d] = 0;
    m_ex[d]    = 1'b0;
  endtask

  function automatic bit mu(input int d, input int i);
    return (m_st[d][i] == H) && (m_hc[d][i] >= ut[d]);
  endfunction

  task automatic model_step(input int d, input logic [7:0] cn);
    int nst[8];
    int nhc[8];
    int n, l, r, ent, hmax;
    bit beats_r, beats_l;
    n    = nn[d];
    ent  = 0;
    hmax = (1 << cw[d]) - 1;
    for (int i = 0; i < n; i++) begin
      l = (i + 1) % n;
      r = (i + n - 1) % n;
      if (m_st[d][i] == E && m_st[d][r] == E) m_ex[d] = 1'b1;
      case (m_st[d][i])
        RD: nst[i] = (m_st[d][l] == T) ? T : RD;
        T:  nst[i] = (m_st[d][r] == RD) ? RD : (cn[i] ? T : H);
        E:  nst[i] = cn[i] ? T : E;
        default: begin
          // In a contested pair the right-hand cell wins unless the other is urgent and it is not.
          beats_r = (m_st[d][r] != H) || (mu(d, i) && !mu(d, r));
          beats_l = (m_st[d][l] != H) || !(mu(d, l) && !mu(d, i));
          nst[i]  = (m_st[d][l] != E && m_st[d][r] != E && beats_r && beats_l) ? E : H;
          if (nst[i] == E) ent++;
        end
      endcase
      if (nst[i] == H && m_st[d][i] == H)
        nhc[i] = (m_hc[d][i] + 1 > hmax) ? hmax : m_hc[d][i] + 1;
      else
        nhc[i] = 0;
    end
    for (int i = 0; i < n; i++) begin
      m_st[d][i] = nst[i];
      m_hc[d][i] = nhc[i];
    end
    m_meals[d] = (m_meals[d] + ent) % (1 << mw[d]);
  endtask

  function automatic logic [15:0] exp_state(input int d);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < nn[d]; i++) v[2*i +: 2] = 2'(m_st[d][i]);
    return v;
  endfunction

  function automatic logic [7:0] exp_urg(input int d);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < nn[d]; i++) v[i] = mu(d, i);
    return v;
  endfunction

  task automatic check_all(input string tag);
    logic [15:0] es0, es1;
    logic [7:0]  eu0, eu1;
    logic [15:0] em1;
    es0 = exp_state(0); eu0 = exp_urg(0);
    es1 = exp_state(1); eu1 = exp_urg(1);
    em1 = 16'(m_meals[1]);
    total++;
    assert (st0 === es0) else begin bad++; $error("FAIL %s d0_state got=%h exp=%h", tag, st0, es0); end
    total++;
    assert (ur0 === eu0) else begin bad++; $error("FAIL %s d0_urgent got=%h exp=%h", tag, ur0, eu0); end
    total++;
    assert (ex0 === m_ex[0]) else begin bad++; $error("FAIL %s d0_excl got=%b exp=%b", tag, ex0, m_ex[0]); end
    total++;
    assert (me0 === 4'(m_meals[0])) else begin bad++; $error("FAIL %s d0_meals got=%0d exp=%0d", tag, me0, m_meals[0]); end
    total++;
    assert (st1 === es1[9:0]) else begin bad++; $error("FAIL %s d1_state got=%h exp=%h", tag, st1, es1[9:0]); end
    total++;
    assert (ur1 === eu1[4:0]) else begin bad++; $error("FAIL %s d1_urgent got=%h exp=%h", tag, ur1, eu1[4:0]); end
    total++;
    assert (ex1 === m_ex[1]) else begin bad++; $error("FAIL %s d1_excl got=%b exp=%b", tag, ex1, m_ex[1]); end
    total++;
    assert (me1 === em1) else begin bad++; $error("FAIL %s d1_meals got=%0d exp=%0d", tag, me1, em1); end
  endtask

  // Called at a falling edge: apply coins, advance one rising edge, check at the next falling edge.
  task automatic cycle(input logic [7:0] c0, input logic [4:0] c1, input string tag);
    coin0 = c0;
    coin1 = c1;
    model_step(0, c0);
    model_step(1, {3'b000, c1});
    @(posedge clock);
    @(negedge clock);
    check_all(tag);
  endtask

  task automatic check_reset_consts(input string tag);
    total++;
    assert (st0 === 16'h0001) else begin bad++; $error("FAIL %s d0_rst_state got=%h exp=0001", tag, st0); end
    total++;
    assert (st1 === 10'h040) else begin bad++; $error("FAIL %s d1_rst_state got=%h exp=040", tag, st1); end
    total++;
    assert (me0 === 4'd0 && ex0 === 1'b0 && ur0 === 8'h00)
      else begin bad++; $error("FAIL %s d0_rst_misc got=%0d/%b/%h exp=0/0/00", tag, me0, ex0, ur0); end
  endtask

  initial begin
    logic [15:0] tok0;
    logic [9:0]  tok1;
    nn[0] = 8; ir[0] = 0; cw[0] = 3; ut[0] = 3; mw[0] = 4;
    nn[1] = 5; ir[1] = 3; cw[1] = 3; ut[1] = 7; mw[1] = 16;
    model_reset(0);
    model_reset(1);

    // Power-on reset, asserted between clock edges.
    #1 reset_n = 1'b0;
    #1 check_all("por");
    check_reset_consts("por");
    @(negedge clock);
    reset_n = 1'b1;

    // All coins 1: the reading token walks up the ring one cell per cycle.
    for (int k = 1; k <= 20; k++) begin
      cycle(8'hFF, 5'h1F, "token");
      tok0 = 16'h0001 << (2 * (k % 8));
      tok1 = 10'h001 << (2 * ((3 + k) % 5));
      total++;
      assert (st0 === tok0) else begin bad++; $error("FAIL token_d0 k=%0d got=%h exp=%h", k, st0, tok0); end
      total++;
      assert (st1 === tok1) else begin bad++; $error("FAIL token_d1 k=%0d got=%h exp=%h", k, st1, tok1); end
    end
    total++;
    assert (me0 === 4'd0 && ex0 === 1'b0) else begin bad++; $error("FAIL token_end got=%0d/%b exp=0/0", me0, ex0); end

    // Reset again, then all coins 0: hungry cells lock up behind eaters and age to urgency/saturation.
    reset_n = 1'b0;
    #1 model_reset(0);
    model_reset(1);
    check_all("rst2");
    reset_n = 1'b1;
    cycle(8'h00, 5'h00, "hungry1");
    total++;
    assert (st0 === 16'hFFF4) else begin bad++; $error("FAIL hungry1_d0 got=%h exp=fff4", st0); end
    total++;
    assert (st1 === 10'h13F) else begin bad++; $error("FAIL hungry1_d1 got=%h exp=13f", st1); end
    for (int k = 0; k < 30; k++) cycle(8'h00, 5'h00, "starve");

    // Random coins, alternating between sparse and dense release to exercise priority.
    for (int k = 0; k < 300; k++) begin
      if (k[4]) cycle(8'($urandom), 5'($urandom), "rand");
      else      cycle(8'($urandom & $urandom & $urandom), 5'($urandom & $urandom & $urandom), "rand_sparse");
    end

    // Short asynchronous reset pulse between edges.
    #2 reset_n = 1'b0;
    model_reset(0);
    model_reset(1);
    #1 check_all("pulse");
    check_reset_consts("pulse");
    reset_n = 1'b1;
    #1;
    cycle(8'($urandom), 5'($urandom), "post_pulse");
    total++;
    assert (st0[3:0] === 4'b0100) else begin bad++; $error("FAIL restart_d0 got=%b exp=0100", st0[3:0]); end
    total++;
    assert (st1[9:6] === 4'b0100) else begin bad++; $error("FAIL restart_d1 got=%b exp=0100", st1[9:6]); end

    for (int k = 0; k < 200; k++) begin
      if (k < 40) cycle(8'h00, 5'h00, "starve2");
      else        cycle(8'($urandom & $urandom), 5'($urandom & $urandom), "rand2");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
